// File: rtl/axi4lite_regbank.sv
// AXI4-Lite slave register bank: parametrised register count/width, byte strobes,
// read-only status registers sourced from reg_in, and per-register write pulses.
module axi4lite_regbank #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 8,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  awready, wready, arready;
  logic                  bvalid, rvalid;
  logic [1:0]            bresp, rresp;
  logic [DATA_WIDTH-1:0] rdata;
  logic [NUM_REGS-1:0]   wr_pulse;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic                  aw_held_n, w_held_n, bvalid_n, rvalid_n;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [31:0]           wr_idx, rd_idx;
  logic                  wr_ok, rd_in_range;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  unused_addr_lsbs;

  // Address bits below the register granularity carry no information.
  assign unused_addr_lsbs = ^{aw_addr[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  always_comb begin
    aw_hs   = S_AXI_AWVALID && awready;
    w_hs    = S_AXI_WVALID && wready;
    ar_hs   = S_AXI_ARVALID && arready;
    wr_addr = aw_held ? aw_addr : S_AXI_AWADDR;
    wr_data = w_held ? w_data : S_AXI_WDATA;
    wr_strb = w_held ? w_strb : S_AXI_WSTRB;
    commit  = (aw_held || aw_hs) && (w_held || w_hs);

    aw_held_n = commit ? 1'b0 : (aw_held || aw_hs);
    w_held_n  = commit ? 1'b0 : (w_held || w_hs);
    bvalid_n  = commit || (bvalid && !S_AXI_BREADY);
    rvalid_n  = ar_hs || (rvalid && !S_AXI_RREADY);

    wr_idx = '0;
    wr_idx[IDX_W-1:0] = wr_addr[ADDR_WIDTH-1:ADDR_LSB];
    rd_idx = '0;
    rd_idx[IDX_W-1:0] = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];

    wr_ok       = 1'b0;
    rd_val      = '0;
    rd_in_range = (rd_idx < NUM_REGS);
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == i && !RO_MASK[i]) wr_ok = 1'b1;
      if (rd_idx == i) rd_val = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs[i] <= RO_MASK[i] ? '0 : RESET_VAL;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      arready  <= 1'b0;
      bvalid   <= 1'b0;
      rvalid   <= 1'b0;
      bresp    <= '0;
      rresp    <= '0;
      rdata    <= '0;
      wr_pulse <= '0;
    end else begin
      aw_held  <= aw_held_n;
      w_held   <= w_held_n;
      bvalid   <= bvalid_n;
      rvalid   <= rvalid_n;
      // Ready flags are registered from next-state so they drop together with VALID.
      awready  <= !aw_held_n && !bvalid_n;
      wready   <= !w_held_n && !bvalid_n;
      arready  <= !rvalid_n;
      wr_pulse <= '0;

      if (aw_hs) aw_addr <= S_AXI_AWADDR;
      if (w_hs) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end

      if (commit) begin
        bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (wr_ok && wr_idx == i) begin
            wr_pulse[i] <= 1'b1;
            for (int unsigned b = 0; b < STRB_W; b++)
              if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end

      if (ar_hs) begin
        rdata <= rd_in_range ? rd_val : '0;
        rresp <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RRESP   = rresp;
  assign S_AXI_RDATA   = rdata;
  assign reg_wr_pulse  = wr_pulse;

endmodule

// File: tb/tb_axi4lite_regbank.sv
// Scoreboard bench for axi4lite_regbank: drivers queue expected responses,
// a negedge monitor pops and compares whenever B or R handshakes.
module tb_axi4lite_regbank;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 8;
  localparam int unsigned AW = 10;
  localparam logic [31:0] RV = 32'h0000_A5A5;

  typedef struct {logic [1:0] resp; logic [7:0] pulse;} wexp_t;
  typedef struct {logic [31:0] data; logic [1:0] resp;} rexp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic bready = 1'b1, rready = 1'b1;
  logic [DW-1:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, arready, bvalid, rvalid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;
  logic [NR*DW-1:0] reg_out, reg_in;
  logic [NR-1:0] reg_wr_pulse;

  int errors = 0, checks = 0;
  int pulse_total = 0, exp_pulses = 0;
  wexp_t wq[$];
  rexp_t rq[$];
  wexp_t mw;
  rexp_t mr;
  logic bvalid_q = 1'b0;

  always #5 clk = ~clk;

  axi4lite_regbank #(
    .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW),
    .RO_MASK(8'h80), .RESET_VAL(RV)
  ) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_in(reg_in), .reg_wr_pulse(reg_wr_pulse)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) bvalid_q = 1'b0;
    else begin
      pulse_total += $countones(reg_wr_pulse);
      if (bvalid && !bvalid_q) begin
        if (wq.size() == 0) check("b_unexpected", 32'd1, 32'd0);
        else check("wr_pulse", {24'd0, reg_wr_pulse}, {24'd0, wq[0].pulse});
      end
      if (bvalid && bready && wq.size() != 0) begin
        mw = wq.pop_front();
        check("bresp", {30'd0, bresp}, {30'd0, mw.resp});
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) check("r_unexpected", 32'd1, 32'd0);
        else begin
          mr = rq.pop_front();
          check("rdata", rdata, mr.data);
          check("rresp", {30'd0, rresp}, {30'd0, mr.resp});
        end
      end
      bvalid_q = bvalid;
    end
  end

  task automatic wait_ready(input int ch, input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if ((ch == 0 && awready) || (ch == 1 && wready) || (ch == 2 && arready)) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: ready=0 after 50 cycles, required 1", name);
        break;
      end
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd, input logic [1:0] er, input logic [7:0] ep);
    wexp_t e;
    e.resp = er;
    e.pulse = ep;
    wq.push_back(e);
    if (ep != 0) exp_pulses++;
    fork
      begin
        repeat (awd) @(posedge clk);
        #1 awaddr = a; awvalid = 1'b1;
        wait_ready(0, "aw");
        @(posedge clk); #1 awvalid = 1'b0;
      end
      begin
        repeat (wd) @(posedge clk);
        #1 wdata = d; wstrb = s; wvalid = 1'b1;
        wait_ready(1, "w");
        @(posedge clk); #1 wvalid = 1'b0;
      end
    join
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [31:0] ed, input logic [1:0] er);
    rexp_t e;
    e.data = ed;
    e.resp = er;
    rq.push_back(e);
    #1 araddr = a; arvalid = 1'b1;
    wait_ready(2, "ar");
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 7; i++) reg_in[i*DW +: DW] = 32'h0BAD_0000 + i;
    reg_in[7*DW +: DW] = 32'hDEAD_BEEF;

    // Reset values and ready release
    #2 rst = 1'b1;
    #1;
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_reg0", reg_out[0 +: DW], RV);
    check("rst_reg7_ro", reg_out[7*DW +: DW], 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("rel_awready_low", {31'd0, awready}, 32'd0);
    @(negedge clk);
    check("rel_ready", {29'd0, awready, wready, arready}, 32'd7);
    @(posedge clk);

    do_read(10'h0C, RV, 2'b00);

    // Fill all registers; register 7 is read-only
    for (int i = 0; i < 8; i++)
      do_write(10'(4*i), 32'(i+1), 4'hF, 0, 0, (i == 7) ? 2'b10 : 2'b00,
               (i == 7) ? 8'h00 : 8'(1 << i));
    for (int i = 0; i < 7; i++) do_read(10'(4*i), 32'(i+1), 2'b00);
    do_read(10'h1C, 32'hDEAD_BEEF, 2'b00);
    check("ro_slice_zero", reg_out[7*DW +: DW], 32'd0);

    // Byte strobes
    do_write(10'h08, 32'hAABB_CCDD, 4'hF, 0, 0, 2'b00, 8'h04);
    do_write(10'h08, 32'h1122_3344, 4'b0101, 0, 0, 2'b00, 8'h04);
    do_read(10'h08, 32'hAA22_CC44, 2'b00);
    do_write(10'h08, 32'hFFFF_FFFF, 4'b0000, 0, 0, 2'b00, 8'h04);
    do_read(10'h08, 32'hAA22_CC44, 2'b00);

    // Out of range and ignored low address bits
    do_write(10'h20, 32'h1234_5678, 4'hF, 0, 0, 2'b10, 8'h00);
    do_read(10'h20, 32'd0, 2'b10);
    do_write(10'h05, 32'h0000_0055, 4'hF, 0, 0, 2'b00, 8'h02);
    do_read(10'h07, 32'h0000_0055, 2'b00);

    // AW three cycles ahead of W, response held off by BREADY
    bready = 1'b0;
    do_write(10'h10, 32'h1234_5678, 4'hF, 0, 3, 2'b00, 8'h10);
    repeat (4) begin
      @(negedge clk);
      check("bhold_valid_rdy", {29'd0, bvalid, awready, wready}, 32'd4);
    end
    check("bhold_reg4", reg_out[4*DW +: DW], 32'h1234_5678);
    @(posedge clk); #1 bready = 1'b1;
    do_read(10'h10, 32'h1234_5678, 2'b00);

    // Read accepted on the write-commit edge sees the old value
    repeat (2) @(posedge clk);
    fork
      do_write(10'h14, 32'hCAFE_F00D, 4'hF, 0, 0, 2'b00, 8'h20);
      do_read(10'h14, 32'd6, 2'b00);
    join
    do_read(10'h14, 32'hCAFE_F00D, 2'b00);

    // Reset while a write response is pending
    bready = 1'b0;
    do_write(10'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b00, 8'h01);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("mid_rst_reg0", reg_out[0 +: DW], RV);
    check("mid_rst_reg4", reg_out[4*DW +: DW], RV);
    wq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bready = 1'b1;
    #1 check("rel2_awready_low", {31'd0, awready}, 32'd0);
    @(negedge clk);
    check("rel2_ready", {29'd0, awready, wready, arready}, 32'd7);
    @(posedge clk);
    do_read(10'h00, RV, 2'b00);
    do_read(10'h04, RV, 2'b00);

    begin
      int n = 0;
      while ((wq.size() != 0 || rq.size() != 0) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("drain", 32'(wq.size() + rq.size()), 32'd0);
    end
    check("pulse_count", 32'(pulse_total), 32'(exp_pulses));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
